// File: rtl/ram_byte_ctrl_if.sv
// Word request bus between the data cache (master) and the byte-wide RAM controller (slave).
// Signal suffixes are named from the controller's point of view.
interface ram_byte_ctrl_if;
   logic        req_ce_i;
   logic        req_we_i;
   logic [3:0]  req_sel_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_data_i;
   logic [31:0] req_data_o;
   logic        req_ack_o;

   modport master (
      output req_ce_i,
      output req_we_i,
      output req_sel_i,
      output req_addr_i,
      output req_data_i,
      input  req_data_o,
      input  req_ack_o
   );

   modport slave (
      input  req_ce_i,
      input  req_we_i,
      input  req_sel_i,
      input  req_addr_i,
      input  req_data_i,
      output req_data_o,
      output req_ack_o
   );
endinterface

// File: rtl/ram_byte_ctrl.sv
// Serialises 32-bit cache requests onto a byte-wide synchronous SRAM, little-endian,
// one byte per cycle, and returns the assembled read word with a one-cycle ack.
module ram_byte_ctrl #(
   parameter int ADDR_W   = 17,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   ram_byte_ctrl_if.slave    req,
   output logic              busy_o,
   output logic [ADDR_W-1:0] ext_addr_o,
   output logic              ext_re_o,
   output logic              ext_we_o,
   output logic [7:0]        ext_data_o,
   input  logic [7:0]        ext_data_i
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      WAIT,
      ACK
   } state_e;

   localparam logic [31:0] ADDR_KEEP = ((32'd1 << ADDR_W) - 32'd1) & ~32'd3;

   state_e            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [1:0]        wait_q, wait_d;
   logic              we_q, we_d;
   logic [3:0]        sel_q, sel_d;
   logic [ADDR_W-3:0] word_addr_q, word_addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       asm_q, asm_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [ADDR_W-1:0] ext_addr_q, ext_addr_d;
   logic [7:0]        ext_data_q, ext_data_d;
   logic              ext_re_q, ext_re_d;
   logic              ext_we_q, ext_we_d;
   logic [READ_LAT-1:0] pipe_vld_q, pipe_vld_d;
   logic [1:0]        pipe_idx_q [READ_LAT];
   logic [1:0]        pipe_idx_d [READ_LAT];
   logic [31:0]       asm_now;
   logic [1:0]        nxt_idx;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^(req.req_addr_i & ~ADDR_KEEP);

   // Each issued read byte travels down a READ_LAT-deep tag pipe; when it pops out,
   // ext_data_i belongs to that byte and is merged into the assembly word.
   always_comb begin
      asm_now = asm_q;
      if (pipe_vld_q[READ_LAT-1]) begin
         asm_now[8*pipe_idx_q[READ_LAT-1] +: 8] = ext_data_i;
      end
      pipe_vld_d    = '0;
      pipe_idx_d    = pipe_idx_q;
      pipe_vld_d[0] = ext_re_q;
      pipe_idx_d[0] = idx_q;
      for (int k = 1; k < READ_LAT; k++) begin
         pipe_vld_d[k] = pipe_vld_q[k-1];
         pipe_idx_d[k] = pipe_idx_q[k-1];
      end
   end

   // The ext_* registers are loaded one cycle ahead, so each WRITE/READ cycle
   // presents the byte that the state register says is current.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      wait_d      = wait_q;
      we_d        = we_q;
      sel_d       = sel_q;
      word_addr_d = word_addr_q;
      wdata_d     = wdata_q;
      asm_d       = asm_now;
      rdata_d     = rdata_q;
      ext_addr_d  = ext_addr_q;
      ext_data_d  = ext_data_q;
      ext_re_d    = 1'b0;
      ext_we_d    = 1'b0;
      nxt_idx     = idx_q + 2'd1;

      case (state_q)
         IDLE: begin
            if (req.req_ce_i) begin
               we_d        = req.req_we_i;
               sel_d       = req.req_sel_i;
               word_addr_d = req.req_addr_i[ADDR_W-1:2];
               wdata_d     = req.req_data_i;
               idx_d       = 2'd0;
               ext_addr_d  = {req.req_addr_i[ADDR_W-1:2], 2'b00};
               if (req.req_we_i) begin
                  state_d    = WRITE;
                  ext_data_d = req.req_data_i[7:0];
                  ext_we_d   = req.req_sel_i[0];
               end else begin
                  state_d  = READ;
                  ext_re_d = 1'b1;
               end
            end
         end

         WRITE: begin
            if (idx_q == 2'd3) begin
               state_d = ACK;
            end else begin
               idx_d      = nxt_idx;
               ext_addr_d = {word_addr_q, nxt_idx};
               ext_data_d = wdata_q[8*nxt_idx +: 8];
               ext_we_d   = sel_q[nxt_idx];
            end
         end

         READ: begin
            if (idx_q == 2'd3) begin
               if (READ_LAT == 1) begin
                  state_d = ACK;
               end else begin
                  state_d = WAIT;
                  wait_d  = 2'(READ_LAT - 2);
               end
            end else begin
               idx_d      = nxt_idx;
               ext_addr_d = {word_addr_q, nxt_idx};
               ext_re_d   = 1'b1;
            end
         end

         WAIT: begin
            if (wait_q == 2'd0) begin
               state_d = ACK;
            end else begin
               wait_d = wait_q - 2'd1;
            end
         end

         ACK: begin
            state_d = IDLE;
            if (!we_q) begin
               rdata_d = asm_now;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         wait_q      <= '0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         word_addr_q <= '0;
         wdata_q     <= '0;
         asm_q       <= '0;
         rdata_q     <= '0;
         ext_addr_q  <= '0;
         ext_data_q  <= '0;
         ext_re_q    <= 1'b0;
         ext_we_q    <= 1'b0;
         pipe_vld_q  <= '0;
         pipe_idx_q  <= '{default: 2'b00};
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         wait_q      <= wait_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         word_addr_q <= word_addr_d;
         wdata_q     <= wdata_d;
         asm_q       <= asm_d;
         rdata_q     <= rdata_d;
         ext_addr_q  <= ext_addr_d;
         ext_data_q  <= ext_data_d;
         ext_re_q    <= ext_re_d;
         ext_we_q    <= ext_we_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_idx_q  <= pipe_idx_d;
      end
   end

   // Byte 3 of a read arrives in the ACK cycle itself, so it bypasses straight to the bus.
   assign req.req_data_o = (state_q == ACK && !we_q) ? asm_now : rdata_q;
   assign req.req_ack_o  = (state_q == ACK);
   assign busy_o         = (state_q != IDLE);
   assign ext_addr_o     = ext_addr_q;
   assign ext_data_o     = ext_data_q;
   assign ext_re_o       = ext_re_q;
   assign ext_we_o       = ext_we_q;

endmodule

// File: tb/tb_ram_byte_ctrl.sv
// Bench for ram_byte_ctrl: two instances (READ_LAT 1 and 3) against byte-array SRAM models,
// checked against a transaction-level memory model and the documented cycle timing.
module tb_ram_byte_ctrl;
   localparam int ADDR_W = 17;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ram_byte_ctrl_if bus0 ();
   ram_byte_ctrl_if bus1 ();

   logic        req_ce   [2];
   logic        req_we   [2];
   logic [3:0]  req_sel  [2];
   logic [31:0] req_addr [2];
   logic [31:0] req_data [2];

   assign bus0.req_ce_i   = req_ce[0];
   assign bus0.req_we_i   = req_we[0];
   assign bus0.req_sel_i  = req_sel[0];
   assign bus0.req_addr_i = req_addr[0];
   assign bus0.req_data_i = req_data[0];
   assign bus1.req_ce_i   = req_ce[1];
   assign bus1.req_we_i   = req_we[1];
   assign bus1.req_sel_i  = req_sel[1];
   assign bus1.req_addr_i = req_addr[1];
   assign bus1.req_data_i = req_data[1];

   logic              busy0, busy1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic              re0, re1, we0, we1;
   logic [7:0]        wd0, wd1, rd_in0, rd_in1;

   ram_byte_ctrl #(.ADDR_W(ADDR_W), .READ_LAT(1)) dut0 (
      .clk(clk), .rst(rst), .req(bus0), .busy_o(busy0),
      .ext_addr_o(addr0), .ext_re_o(re0), .ext_we_o(we0),
      .ext_data_o(wd0), .ext_data_i(rd_in0)
   );

   ram_byte_ctrl #(.ADDR_W(ADDR_W), .READ_LAT(3)) dut1 (
      .clk(clk), .rst(rst), .req(bus1), .busy_o(busy1),
      .ext_addr_o(addr1), .ext_re_o(re1), .ext_we_o(we1),
      .ext_data_o(wd1), .ext_data_i(rd_in1)
   );

   // Synchronous SRAMs; when no read is issued the return path carries junk.
   logic [7:0] sram0 [2**ADDR_W];
   logic [7:0] sram1 [2**ADDR_W];
   logic [7:0] rpipe0;
   logic [7:0] rpipe1 [3];

   always @(posedge clk) begin
      if (we0) sram0[addr0] <= wd0;
      rpipe0 <= re0 ? sram0[addr0] : 8'($urandom);
   end

   always @(posedge clk) begin
      if (we1) sram1[addr1] <= wd1;
      rpipe1[0] <= re1 ? sram1[addr1] : 8'($urandom);
      rpipe1[1] <= rpipe1[0];
      rpipe1[2] <= rpipe1[1];
   end

   assign rd_in0 = rpipe0;
   assign rd_in1 = rpipe1[2];

   logic              o_busy  [2];
   logic              o_ack   [2];
   logic              o_re    [2];
   logic              o_we    [2];
   logic [ADDR_W-1:0] o_addr  [2];
   logic [7:0]        o_wdata [2];
   logic [31:0]       o_rdata [2];

   always_comb begin
      o_busy[0]  = busy0;          o_busy[1]  = busy1;
      o_ack[0]   = bus0.req_ack_o; o_ack[1]   = bus1.req_ack_o;
      o_re[0]    = re0;            o_re[1]    = re1;
      o_we[0]    = we0;            o_we[1]    = we1;
      o_addr[0]  = addr0;          o_addr[1]  = addr1;
      o_wdata[0] = wd0;            o_wdata[1] = wd1;
      o_rdata[0] = bus0.req_data_o;
      o_rdata[1] = bus1.req_data_o;
   end

   // Reference model: the 512-byte test window of each SRAM, plus the last read word.
   logic [7:0]  model_mem [2][512];
   logic [31:0] last_read [2];

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
      return {model_mem[d][{a[8:2], 2'd3}], model_mem[d][{a[8:2], 2'd2}],
              model_mem[d][{a[8:2], 2'd1}], model_mem[d][{a[8:2], 2'd0}]};
   endfunction

   function automatic logic [31:0] sram_word(input int d, input logic [31:0] a);
      logic [ADDR_W-1:0] b;
      b = {a[ADDR_W-1:2], 2'b00};
      if (d == 0) return {sram0[b+3], sram0[b+2], sram0[b+1], sram0[b]};
      return {sram1[b+3], sram1[b+2], sram1[b+1], sram1[b]};
   endfunction

   // Strobes must be mutually exclusive on both instances every cycle.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         checkOutput("re_we_excl0", 32'(re0 & we0), 32'd0);
         checkOutput("re_we_excl1", 32'(re1 & we1), 32'd0);
      end
   end

   // One full transaction on instance d; starts in an IDLE cycle, returns one cycle after the ack edge.
   task automatic applyStimulus(input int d, input logic we, input logic [3:0] sel,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic scramble);
      int          lat;
      int          ack_at;
      logic [31:0] base;
      logic [31:0] exp_word;
      lat      = (d == 0) ? 1 : 3;
      ack_at   = we ? 5 : 4 + lat;
      base     = {15'd0, addr[ADDR_W-1:2], 2'b00};
      exp_word = model_word(d, addr);
      req_ce[d]   = 1'b1;
      req_we[d]   = we;
      req_sel[d]  = sel;
      req_addr[d] = addr;
      req_data[d] = data;
      for (int k = 0; k <= ack_at; k++) begin
         @(negedge clk);
         if (k >= 1 && k <= 4) begin
            checkOutput($sformatf("d%0d c%0d addr", d, k), 32'(o_addr[d]), base + 32'(k - 1));
            checkOutput($sformatf("d%0d c%0d we", d, k), 32'(o_we[d]), 32'(we & sel[k-1]));
            checkOutput($sformatf("d%0d c%0d re", d, k), 32'(o_re[d]), 32'(!we));
            if (we) checkOutput($sformatf("d%0d c%0d wbyte", d, k), 32'(o_wdata[d]), 32'(data[8*(k-1) +: 8]));
         end else begin
            checkOutput($sformatf("d%0d c%0d we_idle", d, k), 32'(o_we[d]), 32'd0);
            checkOutput($sformatf("d%0d c%0d re_idle", d, k), 32'(o_re[d]), 32'd0);
         end
         checkOutput($sformatf("d%0d c%0d busy", d, k), 32'(o_busy[d]), 32'(k >= 1));
         checkOutput($sformatf("d%0d c%0d ack", d, k), 32'(o_ack[d]), 32'(k == ack_at));
         if (k == ack_at) begin
            checkOutput($sformatf("d%0d rdata", d), o_rdata[d], we ? last_read[d] : exp_word);
         end
         @(posedge clk);
         #1;
         if (k == 0 && scramble) begin
            req_we[d]   = 1'($urandom);
            req_sel[d]  = 4'($urandom);
            req_addr[d] = $urandom;
            req_data[d] = $urandom;
         end
      end
      req_ce[d] = 1'b0;
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (sel[b]) model_mem[d][{addr[8:2], 2'(b)}] = data[8*b +: 8];
         end
         checkOutput($sformatf("d%0d sram@%0h", d, base), sram_word(d, addr), model_word(d, addr));
      end else begin
         last_read[d] = exp_word;
      end
   endtask

   function automatic logic [31:0] rand_addr();
      return ($urandom & 32'hFFFE_0000) | (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] orig;
      logic [31:0] nd;
      for (int d = 0; d < 2; d++) begin
         req_ce[d]    = 1'b0;
         req_we[d]    = 1'b0;
         req_sel[d]   = 4'd0;
         req_addr[d]  = 32'd0;
         req_data[d]  = 32'd0;
         last_read[d] = 32'd0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("rst d%0d busy", d), 32'(o_busy[d]), 32'd0);
         checkOutput($sformatf("rst d%0d ack", d), 32'(o_ack[d]), 32'd0);
         checkOutput($sformatf("rst d%0d rdata", d), o_rdata[d], 32'd0);
         checkOutput($sformatf("rst d%0d addr", d), 32'(o_addr[d]), 32'd0);
         checkOutput($sformatf("rst d%0d wbyte", d), 32'(o_wdata[d]), 32'd0);
         checkOutput($sformatf("rst d%0d re", d), 32'(o_re[d]), 32'd0);
         checkOutput($sformatf("rst d%0d we", d), 32'(o_we[d]), 32'd0);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("idle d%0d busy", d), 32'(o_busy[d]), 32'd0);
            checkOutput($sformatf("idle d%0d strobes", d), 32'({o_re[d], o_we[d]}), 32'd0);
         end
      end
      @(posedge clk);
      #1;

      $display("[TB] filling test window");
      for (int d = 0; d < 2; d++) begin
         for (int w = 0; w < 128; w++) begin
            applyStimulus(d, 1'b1, 4'hF, 32'(w) << 2, $urandom, 1'b0);
         end
      end

      $display("[TB] directed transactions");
      for (int d = 0; d < 2; d++) begin
         applyStimulus(d, 1'b1, 4'b1111, 32'h0000_0104, 32'hA1B2_C3D4, 1'b0);
         applyStimulus(d, 1'b1, 4'b0101, 32'h0000_0020, 32'h1122_3344, 1'b0);
         applyStimulus(d, 1'b0, 4'b1111, 32'h0000_0104, 32'h0, 1'b0);
         checkOutput($sformatf("d%0d read 0x104", d), last_read[d], 32'hA1B2_C3D4);
      end
      applyStimulus(1, 1'b1, 4'b0000, 32'h0000_0030, 32'hDEAD_BEEF, 1'b0);

      $display("[TB] back-to-back read then write");
      applyStimulus(0, 1'b0, 4'b0011, 32'h0000_0104, 32'h0, 1'b0);
      applyStimulus(0, 1'b1, 4'b1111, 32'h0000_0108, 32'h5566_7788, 1'b0);

      $display("[TB] reset in the middle of a write");
      orig = model_word(0, 32'h108);
      nd   = $urandom;
      req_ce[0]   = 1'b1;
      req_we[0]   = 1'b1;
      req_sel[0]  = 4'hF;
      req_addr[0] = 32'h0000_0108;
      req_data[0] = nd;
      @(negedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("rstw b0 we", 32'(o_we[0]), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rstw b1 we", 32'(o_we[0]), 32'd1);
      checkOutput("rstw b1 addr", 32'(o_addr[0]), 32'h109);
      @(posedge clk);
      #1;
      rst = 1'b0;
      req_ce[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput($sformatf("rstw c%0d busy", k), 32'(o_busy[0]), 32'd0);
         checkOutput($sformatf("rstw c%0d ack", k), 32'(o_ack[0]), 32'd0);
         checkOutput($sformatf("rstw c%0d strobes", k), 32'({o_re[0], o_we[0]}), 32'd0);
         checkOutput($sformatf("rstw c%0d addr", k), 32'(o_addr[0]), 32'd0);
         checkOutput($sformatf("rstw c%0d wbyte", k), 32'(o_wdata[0]), 32'd0);
         checkOutput($sformatf("rstw c%0d rdata", k), o_rdata[0], 32'd0);
         @(posedge clk);
         #1;
      end
      model_mem[0][9'h108] = nd[7:0];
      model_mem[0][9'h109] = nd[15:8];
      last_read[0] = 32'd0;
      last_read[1] = 32'd0;
      checkOutput("rstw sram", sram_word(0, 32'h108), model_word(0, 32'h108));
      applyStimulus(0, 1'b0, 4'hF, 32'h0000_0108, 32'h0, 1'b0);
      checkOutput("rstw readback", last_read[0], {orig[31:16], nd[15:0]});

      $display("[TB] randomized transactions");
      for (int n = 0; n < 80; n++) begin
         applyStimulus(int'($urandom_range(0, 1)), 1'($urandom), 4'($urandom),
                       rand_addr(), $urandom, 1'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_byte_ctrl.md
Name: ram_byte_ctrl

Overview:
- RAM-side responder for the 32-bit word requests issued by the data cache: ce/we/sel/addr/data in, read data plus completion out.
- Serialises each 32-bit request onto a byte-wide external synchronous SRAM, one byte per cycle, little-endian.
- Returns assembled read data and a one-cycle ack.
- busy_o feeds the stall controller.

Parameters:
- ADDR_W, 17, width of external byte address; req_addr_i bits above ADDR_W-1 are ignored.
- READ_LAT, 1, cycles from ext_re_o/ext_addr_o to valid ext_data_i; legal range 1..3.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- req_ce_i  in  1  request valid; held stable by requester until req_ack_o
- req_we_i  in  1  1 = write, 0 = read
- req_sel_i  in  4  byte enables; bit i covers data[8i+7:8i]
- req_addr_i  in  32  byte address; bits [1:0] ignored (word aligned)
- req_data_i  in  32  write data
- req_data_o  out  32  read data; valid in ack cycle of a read, held until next read ack
- req_ack_o  out  1  one-cycle completion pulse
- busy_o  out  1  high whenever FSM is not IDLE
- ext_addr_o  out  ADDR_W  external byte address
- ext_re_o  out  1  external read strobe
- ext_we_o  out  1  external write strobe
- ext_data_o  out  8  external write byte
- ext_data_i  in  8  external read byte

Behaviour:
- Reset: when rst is sampled high, the following are 0 from the next edge: state=IDLE, req_data_o, req_ack_o, busy_o, ext_addr_o, ext_re_o, ext_we_o, ext_data_o. Byte counters and capture register are cleared.
- Reset mid-operation aborts at once: no further ext strobes and no ack.
- States: IDLE, WRITE, READ, WAIT, ACK.
- IDLE:
  - If req_ce_i=1, latch we/sel/addr[ADDR_W-1:2]/data, clear byte index i=0, go to WRITE (we=1) or READ (we=0).
  - Later changes on req_* inputs do not affect the transaction in flight.
- Byte i address: {addr[ADDR_W-1:2], i[1:0]}. Byte i of the word is data[8i+7:8i].
- WRITE: 4 cycles, i=0..3.
  - ext_addr_o = byte i address; ext_data_o = data byte i; ext_we_o = sel[i]; ext_re_o = 0.
  - After i=3, go to ACK.
  - sel=0000 still takes 4 cycles, with no ext_we_o pulse.
- READ: 4 cycles, i=0..3.
  - ext_re_o = 1 and ext_addr_o = byte i address, issued regardless of sel.
  - ext_data_i is captured into byte i of the assembly register exactly READ_LAT cycles after byte i is issued.
  - After i=3, go to WAIT.
- WAIT: stay until byte 3 is captured (READ_LAT-1 cycles after leaving READ, 0 cycles when READ_LAT=1), then go to ACK. ext strobes are 0.
- ACK (one cycle):
  - req_ack_o = 1.
  - For a read, req_data_o = assembled word, all 4 bytes regardless of sel; masking is the requester's job.
  - For a write, req_data_o is unchanged.
  - Next state is IDLE.
- Latency, with request accepted in cycle 0:
  - write ack in cycle 5;
  - read ack in cycle 5+READ_LAT-1, i.e. cycle 5 for READ_LAT=1.
- Back-to-back: a request with req_ce_i still high in the cycle after ACK (IDLE) is a new request. The requester must drop or replace req_ce_i on the ack edge.
- busy_o = 1 in WRITE/READ/WAIT/ACK, 0 in IDLE.
- ext_re_o and ext_we_o are never high in the same cycle.
- Outside the active states, ext_addr_o and ext_data_o hold their last value. Strobes are 0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs 0. With req_ce_i=0, busy_o stays 0 and no strobes appear.
- Full write: addr=0x00000104, sel=1111, data=0xA1B2C3D4 -> ext_we_o pulses in cycles 1–4 at addresses 0x104..0x107 with bytes D4,C3,B2,A1; req_ack_o in cycle 5; busy_o high cycles 1–5.
- Partial write: sel=0101, data=0x11223344, addr=0x20 -> ext_we_o high only in the cycles for 0x20 (byte 44) and 0x22 (byte 22); 0x21 and 0x23 are unchanged in the SRAM model.
- Read, READ_LAT=1 and READ_LAT=3: SRAM holds 0x104..0x107 = D4,C3,B2,A1 -> req_data_o = 0xA1B2C3D4 at ack; ack in cycle 5 and cycle 7 respectively.
- Back-to-back: read 0x104 with req_ce_i held through ack, then write 0x108 presented on the ack edge -> second transaction starts the cycle after ack; read data is held through the write ack.
- Reset mid-write: rst asserted after the byte-1 cycle of a write -> no ext_we_o for bytes 2–3, no ack; outputs 0 next cycle; a subsequent read returns the original bytes 2–3.
